hi_lo_multiply_divide_unit: RTL and testbench

Execute-stage multiply/divide unit owning the architectural HI and LO registers. It consumes the function code, the hi/lo enable and the two forwarded operands that the decode/execute pipeline register delivers. It runs MULT/MULTU/DIV/DIVU as multi-cycle iterative operations, and handles MTHI/MTLO/MFHI/MFLO in a single cycle. It raises a stall request to the hazard unit whenever a hi/lo instruction reaches execute while an operation is still in flight.

---
 rtl/hi_lo_multiply_divide_unit.sv | 164 ++++++++++++++++
 tb/tb_hi_lo_multiply_divide_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hi_lo_multiply_divide_unit.sv
// Execute-stage HI/LO unit: iterative MULT/MULTU/DIV/DIVU plus single-cycle MTHI/MTLO/MFHI/MFLO.
// Define HI_LO_FAST_MULTIPLY_EN to replace the 32-cycle multiply with a single-cycle multiplier.
module hi_lo_multiply_divide_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        hi_lo_enable_execute,
    input  logic [5:0]  ALU_function_execute,
    input  logic [31:0] source_a_execute,
    input  logic [31:0] source_b_execute,
    output logic [31:0] hi_lo_read_data_execute,
    output logic        hi_lo_busy,
    output logic        hi_lo_stall_execute
);
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state;
    logic [5:0]  counter;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] operand;
    logic        negate_low;
    logic        negate_high;

    // Function decode
    logic is_mult, is_multu, is_div, is_divu;
    logic is_multiply, is_divide, is_move_from, is_move_to, is_hi_lo_function;
    logic signed_op, result_negative;

    assign is_mult           = (ALU_function_execute == FUNCT_MULT);
    assign is_multu          = (ALU_function_execute == FUNCT_MULTU);
    assign is_div            = (ALU_function_execute == FUNCT_DIV);
    assign is_divu           = (ALU_function_execute == FUNCT_DIVU);
    assign is_multiply       = is_mult | is_multu;
    assign is_divide         = is_div | is_divu;
    assign is_move_from      = (ALU_function_execute == FUNCT_MFHI) | (ALU_function_execute == FUNCT_MFLO);
    assign is_move_to        = (ALU_function_execute == FUNCT_MTHI) | (ALU_function_execute == FUNCT_MTLO);
    assign is_hi_lo_function = is_multiply | is_divide | is_move_from | is_move_to;
    assign signed_op         = is_mult | is_div;
    assign result_negative   = signed_op & (source_a_execute[31] ^ source_b_execute[31]);

    // Iterations run on unsigned magnitudes; the sign is restored on the last iteration.
    logic [31:0] magnitude_a, magnitude_b;
    assign magnitude_a = (signed_op && source_a_execute[31]) ? (32'd0 - source_a_execute) : source_a_execute;
    assign magnitude_b = (signed_op && source_b_execute[31]) ? (32'd0 - source_b_execute) : source_b_execute;

`ifdef HI_LO_FAST_MULTIPLY_EN
    // Sign-extended 64x64 product keeps the low 64 bits exact for both MULT and MULTU.
    logic [63:0] extended_a, extended_b, fast_product;
    assign extended_a   = {{32{signed_op & source_a_execute[31]}}, source_a_execute};
    assign extended_b   = {{32{signed_op & source_b_execute[31]}}, source_b_execute};
    assign fast_product = extended_a * extended_b;
`endif

    // Shift-add step: acc_lo holds the remaining multiplier bits, acc_hi the partial sum.
    logic [32:0] mul_sum;
    logic [63:0] mul_product, mul_result;
    assign mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
    assign mul_product = {mul_sum, acc_lo[31:1]};
    assign mul_result  = negate_low ? (64'd0 - mul_product) : mul_product;

    // Restoring step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    logic [32:0] div_shifted;
    logic        div_fits;
    logic [31:0] remainder_next, quotient_next, remainder_result, quotient_result;
    assign div_shifted      = {acc_hi, acc_lo[31]};
    assign div_fits         = (div_shifted >= {1'b0, operand});
    assign remainder_next   = div_fits ? (div_shifted[31:0] - operand) : div_shifted[31:0];
    assign quotient_next    = {acc_lo[30:0], div_fits};
    assign remainder_result = negate_high ? (32'd0 - remainder_next) : remainder_next;
    // A zero divisor leaves the restored dividend in the remainder; only LO needs forcing.
    assign quotient_result  = (operand == 32'd0) ? 32'hFFFF_FFFF :
                              (negate_low ? (32'd0 - quotient_next) : quotient_next);

    assign hi_lo_read_data_execute = (ALU_function_execute == FUNCT_MFHI) ? hi : lo;
    assign hi_lo_stall_execute     = hi_lo_enable_execute & hi_lo_busy & is_hi_lo_function;

    // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= 6'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            acc_hi      <= 32'd0;
            acc_lo      <= 32'd0;
            operand     <= 32'd0;
            negate_low  <= 1'b0;
            negate_high <= 1'b0;
            hi_lo_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hi_lo_enable_execute) begin
                        if (is_multiply) begin
`ifdef HI_LO_FAST_MULTIPLY_EN
                            {hi, lo} <= fast_product;
`else
                            state       <= MUL;
                            hi_lo_busy  <= 1'b1;
                            counter     <= 6'd0;
                            acc_hi      <= 32'd0;
                            acc_lo      <= magnitude_b;
                            operand     <= magnitude_a;
                            negate_low  <= result_negative;
                            negate_high <= result_negative;
`endif
                        end else if (is_divide) begin
                            state       <= DIV;
                            hi_lo_busy  <= 1'b1;
                            counter     <= 6'd0;
                            acc_hi      <= 32'd0;
                            acc_lo      <= magnitude_a;
                            operand     <= magnitude_b;
                            negate_low  <= result_negative;
                            negate_high <= signed_op & source_a_execute[31];
                        end else if (ALU_function_execute == FUNCT_MTHI) begin
                            hi <= source_a_execute;
                        end else if (ALU_function_execute == FUNCT_MTLO) begin
                            lo <= source_a_execute;
                        end
                    end
                end

                MUL: begin
                    {acc_hi, acc_lo} <= mul_product;
                    counter          <= counter + 6'd1;
                    if (counter == 6'd31) begin
                        {hi, lo}   <= mul_result;
                        state      <= IDLE;
                        hi_lo_busy <= 1'b0;
                    end
                end

                DIV: begin
                    acc_hi  <= remainder_next;
                    acc_lo  <= quotient_next;
                    counter <= counter + 6'd1;
                    if (counter == 6'd31) begin
                        hi         <= remainder_result;
                        lo         <= quotient_result;
                        state      <= IDLE;
                        hi_lo_busy <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    hi_lo_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hi_lo_multiply_divide_unit.sv
// Self-checking bench for hi_lo_multiply_divide_unit: directed plan cases plus randomized
// operations compared against an arithmetic reference model of HI/LO.
module tb_hi_lo_multiply_divide_unit;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;

`ifdef HI_LO_FAST_MULTIPLY_EN
    localparam int MUL_CYCLES = 0;
`else
    localparam int MUL_CYCLES = 32;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        hi_lo_enable_execute;
    logic [5:0]  ALU_function_execute;
    logic [31:0] source_a_execute;
    logic [31:0] source_b_execute;
    logic [31:0] hi_lo_read_data_execute;
    logic        hi_lo_busy;
    logic        hi_lo_stall_execute;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    always #5 clk = ~clk;

    hi_lo_multiply_divide_unit dut (
        .clk                     (clk),
        .reset                   (reset),
        .hi_lo_enable_execute    (hi_lo_enable_execute),
        .ALU_function_execute    (ALU_function_execute),
        .source_a_execute        (source_a_execute),
        .source_b_execute        (source_b_execute),
        .hi_lo_read_data_execute (hi_lo_read_data_execute),
        .hi_lo_busy              (hi_lo_busy),
        .hi_lo_stall_execute     (hi_lo_stall_execute)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%h, expected 0x%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] reference_result(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        int sx, sy, q, r;
        sx = x;
        sy = y;
        case (f)
            F_MULT:  return longint'(sx) * longint'(sy);
            F_MULTU: return {32'd0, x} * {32'd0, y};
            F_DIVU: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            F_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic read_hi_lo(input string tag);
        hi_lo_enable_execute = 1'b1;
        ALU_function_execute = F_MFHI;
        #1;
        check({tag, " HI"}, hi_lo_read_data_execute, model_hi);
        ALU_function_execute = F_MFLO;
        #1;
        check({tag, " LO"}, hi_lo_read_data_execute, model_lo);
        hi_lo_enable_execute = 1'b0;
        ALU_function_execute = F_ADD;
    endtask

    // Issue one iterative op, count busy cycles with a non-hi/lo instruction in execute, then read back.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] expected;
        int          expected_cycles;
        int          n;
        logic        stall_seen;
        expected        = reference_result(f, x, y);
        expected_cycles = (f == F_MULT || f == F_MULTU) ? MUL_CYCLES : 32;
        hi_lo_enable_execute = 1'b1;
        ALU_function_execute = f;
        source_a_execute     = x;
        source_b_execute     = y;
        #1;
        check({tag, " stall at issue"}, {31'd0, hi_lo_stall_execute}, 32'd0);
        tick();
        hi_lo_enable_execute = 1'b0;
        ALU_function_execute = F_ADD;
        source_a_execute     = $urandom;
        source_b_execute     = $urandom;
        #1;
        n          = 0;
        stall_seen = 1'b0;
        while (hi_lo_busy && n < 40) begin
            stall_seen |= hi_lo_stall_execute;
            n++;
            tick();
        end
        check({tag, " busy cycles"}, 32'(n), 32'(expected_cycles));
        check({tag, " non-hi/lo stall"}, {31'd0, stall_seen}, 32'd0);
        model_hi = expected[63:32];
        model_lo = expected[31:0];
        read_hi_lo(tag);
        tick();
    endtask

    initial begin
        int          n;
        logic [63:0] expected;

        reset                = 1'b1;
        hi_lo_enable_execute = 1'b0;
        ALU_function_execute = F_ADD;
        source_a_execute     = 32'd0;
        source_b_execute     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, hi_lo_busy}, 32'd0);
        read_hi_lo("reset");
        hi_lo_enable_execute = 1'b1;
        ALU_function_execute = F_MULT;
        #1;
        check("reset stall", {31'd0, hi_lo_stall_execute}, 32'd0);
        hi_lo_enable_execute = 1'b0;
        ALU_function_execute = F_ADD;
        reset = 1'b0;
        tick();

        run_op("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult -3x5", F_MULT, 32'hFFFF_FFFD, 32'd5);
        run_op("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("div overflow", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu by zero", F_DIVU, 32'd7, 32'd0);
        run_op("div neg by zero", F_DIV, 32'hFFFF_FF00, 32'd0);

        // MTLO/MTHI are visible to an MF in the next cycle and touch only their own register.
        hi_lo_enable_execute = 1'b1;
        ALU_function_execute = F_MTLO;
        source_a_execute     = 32'h1234_5678;
        tick();
        model_lo = 32'h1234_5678;
        ALU_function_execute = F_MTHI;
        source_a_execute     = 32'hCAFE_F00D;
        tick();
        model_hi = 32'hCAFE_F00D;
        read_hi_lo("mt");
        tick();

        // MFLO arriving one cycle after a MULTU accept stalls until the result lands.
        hi_lo_enable_execute = 1'b1;
        ALU_function_execute = F_MULTU;
        source_a_execute     = 32'd6;
        source_b_execute     = 32'd7;
        tick();
        hi_lo_enable_execute = 1'b0;
        ALU_function_execute = F_ADD;
        #1;
        check("mf wait busy", {31'd0, hi_lo_busy}, (MUL_CYCLES != 0) ? 32'd1 : 32'd0);
        check("mf wait non-hi/lo stall", {31'd0, hi_lo_stall_execute}, 32'd0);
        tick();
        hi_lo_enable_execute = 1'b1;
        ALU_function_execute = F_MFLO;
        #1;
        n = 0;
        while (hi_lo_stall_execute && n < 40) begin
            n++;
            tick();
        end
        check("mf stall cycles", 32'(n), (MUL_CYCLES != 0) ? 32'(MUL_CYCLES - 1) : 32'd0);
        expected = reference_result(F_MULTU, 32'd6, 32'd7);
        model_hi = expected[63:32];
        model_lo = expected[31:0];
        check("mf after stall", hi_lo_read_data_execute, model_lo);
        hi_lo_enable_execute = 1'b0;
        ALU_function_execute = F_ADD;
        tick();

        // Reset ten cycles into a DIV aborts it and clears HI/LO.
        hi_lo_enable_execute = 1'b1;
        ALU_function_execute = F_DIV;
        source_a_execute     = $urandom;
        source_b_execute     = $urandom | 32'd1;
        tick();
        hi_lo_enable_execute = 1'b0;
        ALU_function_execute = F_ADD;
        repeat (10) tick();
        check("div busy before reset", {31'd0, hi_lo_busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort busy", {31'd0, hi_lo_busy}, 32'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        read_hi_lo("abort");
        tick();
        reset = 1'b0;
        tick();
        run_op("divu after reset", F_DIVU, $urandom, 32'($urandom_range(1, 1000)));

        for (int i = 0; i < 24; i++) begin
            run_op("random", F_MULT + 6'($urandom_range(0, 3)), pick_operand(), pick_operand());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
